// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: runs a T-flip-flop up/down counter from lo to hi and back
// for a commanded number of sweeps. It supports pause and abort, and signals
// completion with a one-cycle done pulse and rejection with a one-cycle err pulse.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// UP    | counting toward hi
// DOWN  | counting toward lo, turns around or finishes at lo
module updown_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_lo,
  input  logic [WIDTH-1:0]   cmd_hi,
  input  logic [SWEEP_W-1:0] cmd_sweeps,
  input  logic               pause,
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic [SWEEP_W-1:0] sweeps_left,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] sweeps_left_q, sweeps_left_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               step_en;
  logic               load;
  logic [WIDTH-1:0]   tog;

  // T-flip-flop toggle enables. The step direction is the next-cycle mode, so
  // the turn-around step at hi is already a down step.
  always_comb begin : tff_chain
    logic up_c;
    logic dn_c;
    up_c = 1'b1;
    dn_c = 1'b1;
    tog  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = step_en & (dir_d ? dn_c : up_c);
      up_c   = up_c & count_q[i];
      dn_c   = dn_c & ~count_q[i];
    end
  end

  // Counter next value: the parallel load of lo, otherwise the toggled chain.
  always_comb begin
    count_d = load ? cmd_lo : (count_q ^ tog);
  end

  // Next-state logic with step, load and pulse decisions.
  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    sweeps_left_d = sweeps_left_q;
    dir_d         = dir_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    step_en       = 1'b0;
    load          = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if ((cmd_lo >= cmd_hi) || (cmd_sweeps == '0)) begin
            err_d = 1'b1;
          end else begin
            lo_d          = cmd_lo;
            hi_d          = cmd_hi;
            load          = 1'b1;
            sweeps_left_d = cmd_sweeps;
            dir_d         = 1'b0;
            state_d       = UP;
          end
        end
      end
      UP: begin
        if (abort) begin
          state_d       = IDLE;
          dir_d         = 1'b0;
          sweeps_left_d = '0;
        end else if (!pause) begin
          step_en = 1'b1;
          if (count_q == hi_q) begin
            dir_d   = 1'b1;
            state_d = DOWN;
          end
        end
      end
      DOWN: begin
        if (abort) begin
          state_d       = IDLE;
          dir_d         = 1'b0;
          sweeps_left_d = '0;
        end else if (!pause) begin
          if (count_q > lo_q) begin
            step_en = 1'b1;
          end else if (sweeps_left_q > SWEEP_W'(1)) begin
            sweeps_left_d = sweeps_left_q - SWEEP_W'(1);
            dir_d         = 1'b0;
            step_en       = 1'b1;
            state_d       = UP;
          end else begin
            sweeps_left_d = '0;
            dir_d         = 1'b0;
            done_d        = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
      sweeps_left_q <= '0;
      dir_q         <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      sweeps_left_q <= sweeps_left_d;
      dir_q         <= dir_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q == UP) || (state_q == DOWN);
  assign count       = count_q;
  assign dir         = dir_q;
  assign sweeps_left = sweeps_left_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_lo = '0;
  logic [3:0] cmd_hi = '0;
  logic [3:0] cmd_sweeps = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       dir;
  logic       busy;
  logic [3:0] sweeps_left;
  logic       done;
  logic       err;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic [3:0] sl;
    logic       done;
    logic       err;
    logic       ready;
  } exp_t;

  exp_t q[$];

  updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_sweeps(cmd_sweeps),
    .pause(pause), .abort(abort),
    .count(count), .dir(dir), .busy(busy), .sweeps_left(sweeps_left),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input int c, input int cnt, input int d, input int b,
                      input int sl, input int dn, input int er, input int rdy);
    exp_t e;
    e.cyc = c; e.count = 4'(cnt); e.dir = 1'(d); e.busy = 1'(b);
    e.sl = 4'(sl); e.done = 1'(dn); e.err = 1'(er); e.ready = 1'(rdy);
    q.push_back(e);
  endtask

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (count !== e.count || dir !== e.dir || busy !== e.busy || sweeps_left !== e.sl ||
        done !== e.done || err !== e.err || cmd_ready !== e.ready) begin
      errors++;
      $display("FAIL %s cyc=%0d got count=%0d dir=%b busy=%b sl=%0d done=%b err=%b rdy=%b want count=%0d dir=%b busy=%b sl=%0d done=%b err=%b rdy=%b",
               name, e.cyc, count, dir, busy, sweeps_left, done, err, cmd_ready,
               e.count, e.dir, e.busy, e.sl, e.done, e.err, e.ready);
    end
  endtask

  // Monitor: compare every expectation stamped with the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL stale expectation cyc=%0d now=%0d", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      compare("sb", q.pop_front());
    end
  end

  // Called #1 after a rising edge; returns after the accepting edge.
  task automatic issue(input int lo, input int hi, input int sw, output int a);
    cmd_lo = 4'(lo); cmd_hi = 4'(hi); cmd_sweeps = 4'(sw);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    a = cyc;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Expected trajectory of a full multi-sweep command, done placed by formula.
  task automatic push_sweep(input int a, input int lo, input int hi, input int n);
    int c, d, sl, len;
    c = lo; d = 0; sl = n;
    len = n * 2 * (hi - lo);
    for (int t = 0; t <= len; t++) begin
      push(a + t, c, d, 1, sl, 0, 0, 0);
      if (d == 0) begin
        if (c == hi) begin d = 1; c = c - 1; end
        else c = c + 1;
      end else if (c > lo) begin
        c = c - 1;
      end else begin
        sl = sl - 1; d = 0; c = c + 1;
      end
    end
    push(a + len + 1, lo, 0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    int a, a2, e;
    int cnt1[7] = '{2, 3, 4, 5, 4, 3, 2};
    int dir1[7] = '{0, 0, 0, 0, 1, 1, 1};
    int cntp[14] = '{1, 2, 3, 4, 5, 6, 5, 4, 4, 4, 4, 3, 2, 1};
    int dirp[14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    push(cyc, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lo=2 hi=5 one sweep, then back-to-back command in the done cycle
    issue(2, 5, 1, a);
    for (int t = 0; t < 7; t++) push(a + t, cnt1[t], dir1[t], 1, 1, 0, 0, 0);
    push(a + 7, 2, 0, 0, 0, 1, 0, 1);
    wait_cyc(a + 7);
    issue(1, 3, 1, a2);
    push(a2 + 0, 1, 0, 1, 1, 0, 0, 0);
    push(a2 + 1, 2, 0, 1, 1, 0, 0, 0);
    push(a2 + 2, 3, 0, 1, 1, 0, 0, 0);
    push(a2 + 3, 2, 1, 1, 1, 0, 0, 0);
    push(a2 + 4, 1, 1, 1, 1, 0, 0, 0);
    push(a2 + 5, 1, 0, 0, 0, 1, 0, 1);
    push(a2 + 6, 1, 0, 0, 0, 0, 0, 1);
    wait_cyc(a2 + 6);

    // illegal commands: lo==hi, then zero sweeps
    issue(6, 6, 1, e);
    push(e, 1, 0, 0, 0, 0, 1, 1);
    push(e + 1, 1, 0, 0, 0, 0, 0, 1);
    wait_cyc(e + 1);
    issue(3, 8, 0, e);
    push(e, 1, 0, 0, 0, 0, 1, 1);
    push(e + 1, 1, 0, 0, 0, 0, 0, 1);
    wait_cyc(e + 1);

    // full range, two sweeps
    issue(0, 15, 2, a);
    push_sweep(a, 0, 15, 2);
    wait_cyc(a + 62);

    // pause for 3 cycles at count=4 while going down
    issue(1, 6, 1, a);
    for (int t = 0; t < 14; t++) push(a + t, cntp[t], dirp[t], 1, 1, 0, 0, 0);
    push(a + 14, 1, 0, 0, 0, 1, 0, 1);
    wait_cyc(a + 7);
    pause = 1'b1;
    wait_cyc(a + 10);
    pause = 1'b0;
    wait_cyc(a + 14);
    @(posedge clk); #1;

    // pause together with abort at count=9
    issue(0, 12, 1, a);
    for (int t = 0; t <= 9; t++) push(a + t, t, 0, 1, 1, 0, 0, 0);
    push(a + 10, 9, 0, 0, 0, 0, 0, 1);
    push(a + 11, 9, 0, 0, 0, 0, 0, 1);
    wait_cyc(a + 9);
    pause = 1'b1; abort = 1'b1;
    wait_cyc(a + 10);
    pause = 1'b0; abort = 1'b0;
    wait_cyc(a + 11);

    // abort in IDLE does not cancel a command accepted that cycle
    abort = 1'b1;
    issue(2, 4, 1, a);
    abort = 1'b0;
    push(a + 0, 2, 0, 1, 1, 0, 0, 0);
    push(a + 1, 3, 0, 1, 1, 0, 0, 0);
    push(a + 2, 4, 0, 1, 1, 0, 0, 0);
    push(a + 3, 3, 1, 1, 1, 0, 0, 0);
    push(a + 4, 2, 1, 1, 1, 0, 0, 0);
    push(a + 5, 2, 0, 0, 0, 1, 0, 1);
    wait_cyc(a + 5);

    // asynchronous reset during UP at count=7
    issue(0, 12, 1, a);
    for (int t = 0; t <= 7; t++) push(a + t, t, 0, 1, 1, 0, 0, 0);
    wait_cyc(a + 7);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    begin
      exp_t r;
      r.cyc = cyc; r.count = 4'd0; r.dir = 1'b0; r.busy = 1'b0; r.sl = 4'd0;
      r.done = 1'b0; r.err = 1'b0; r.ready = 1'b1;
      compare("async_reset", r);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(cyc, 0, 0, 0, 0, 0, 0, 1);
    push(cyc + 1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) begin @(posedge clk); #1; end

    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unchecked expectation cyc=%0d", q[0].cyc);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
